sevenseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit, active-low seven-segment display. It sequences digit enables with an anti-ghosting blank interval and PWM brightness, and decodes 4-bit hex per digit. A double-buffered frame register is loaded over a valid/ready handshake, so effect engines (scroll, bounce, counters) can hand it whole frames without tearing. It sits between the effect logic and the board pins `seg`/`dp`/`an`.

---
 rtl/sevenseg_scan_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit, active-low seven-segment
// display. Each digit slot is SlotLen cycles long. It starts with an all-off
// blank interval against ghosting, then a PWM-sized ON window, then OFF for
// the rest of the slot. Frames arrive over a valid/ready handshake into a
// shadow buffer. They are copied to the active buffer only at a frame
// boundary, so the display never tears.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   wr_valid     in   frame write request
//   wr_ready     out  shadow buffer empty, write can be accepted
//   wr_data      in   digit i = wr_data[5i+4:5i] = {dp_on, hex[3:0]}
//   brightness   in   duty level 0..7, sampled at the start of each slot
//   seg          out  active-low segments {g,f,e,d,c,b,a}
//   dp           out  active-low decimal point
//   an           out  active-low digit enables, an[i] drives digit i
//   frame_start  out  one-cycle pulse at the start of the digit-0 slot
//   cur_digit    out  index of the current slot
//
// All display outputs are registered. The value after edge k reflects the
// counter state of cycle k-1.

module sevenseg_scan_ctrl #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [19:0] wr_data,
  input  logic [2:0]  brightness,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start,
  output logic [1:0]  cur_digit
);

  localparam int unsigned SlotLen = CLK_FREQ / (4 * REFRESH_HZ);
  localparam int unsigned Step    = (SlotLen - BLANK_CYCLES) / 8;
  localparam int unsigned CntW    = (SlotLen > 1) ? $clog2(SlotLen) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SlotLen - 1);

  typedef enum logic [1:0] {
    StBlank,
    StOn,
    StOff
  } phase_e;

  // State registers
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_digit;
  logic [2:0]      r_bright;
  logic [19:0]     r_active;
  logic [19:0]     r_shadow;
  logic            r_full;

  // Output registers
  logic [6:0]      r_seg;
  logic            r_dp;
  logic [3:0]      r_an;
  logic            r_frame_start;
  logic [1:0]      r_cur_digit;

  // Next-state / decode wires
  logic [CntW-1:0] w_cnt_d;
  logic [1:0]      w_digit_d;
  logic [2:0]      w_bright;
  logic            w_slot_last;
  logic            w_swap;
  logic            w_accept;
  logic            w_full_d;
  logic [31:0]     w_cnt_ext;
  logic [31:0]     w_win;
  phase_e          w_phase;
  logic [4:0]      w_digit_data;
  logic [6:0]      w_seg_d;
  logic            w_dp_d;
  logic [3:0]      w_an_d;
  logic            w_frame_start_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    w_cnt_d         = r_cnt + CntW'(1);
    w_digit_d       = r_digit;
    w_bright        = r_bright;
    w_full_d        = r_full;
    w_phase         = StOff;
    w_digit_data    = 5'd0;
    w_seg_d         = 7'h7f;
    w_dp_d          = 1'b1;
    w_an_d          = 4'hf;
    w_frame_start_d = 1'b0;

    w_slot_last = (r_cnt == CntLast);
    if (w_slot_last) begin
      w_cnt_d   = '0;
      w_digit_d = r_digit + 2'd1;
    end

    // The slot's brightness is taken live in its first cycle and held after,
    // so the window is correct even when there is no blank interval.
    if (r_cnt == '0) begin
      w_bright = brightness;
    end

    // Swap needs a frame already waiting before this edge; an accept on the
    // same edge is impossible because wr_ready is low whenever full is set.
    w_swap   = w_slot_last && (r_digit == 2'd3) && r_full;
    w_accept = wr_valid && !r_full;
    if (w_swap) begin
      w_full_d = 1'b0;
    end else if (w_accept) begin
      w_full_d = 1'b1;
    end

    w_cnt_ext = 32'(r_cnt);
    w_win     = Step * (32'(w_bright) + 32'd1);
    if (w_cnt_ext < BLANK_CYCLES) begin
      w_phase = StBlank;
    end else if ((w_cnt_ext - BLANK_CYCLES) < w_win) begin
      w_phase = StOn;
    end else begin
      w_phase = StOff;
    end

    unique case (r_digit)
      2'd0: w_digit_data = r_active[4:0];
      2'd1: w_digit_data = r_active[9:5];
      2'd2: w_digit_data = r_active[14:10];
      2'd3: w_digit_data = r_active[19:15];
      default: w_digit_data = 5'd0;
    endcase

    if (w_phase == StOn) begin
      w_an_d  = ~(4'b0001 << r_digit);
      w_seg_d = hex_to_seg(w_digit_data[3:0]);
      w_dp_d  = ~w_digit_data[4];
    end

    w_frame_start_d = (r_cnt == '0) && (r_digit == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_digit  <= 2'd0;
      r_bright <= 3'd0;
      r_active <= 20'd0;
      r_shadow <= 20'd0;
      r_full   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_digit  <= w_digit_d;
      r_bright <= w_bright;
      r_full   <= w_full_d;
      if (w_swap) begin
        r_active <= r_shadow;
      end
      if (w_accept) begin
        r_shadow <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg         <= 7'h7f;
      r_dp          <= 1'b1;
      r_an          <= 4'hf;
      r_frame_start <= 1'b0;
      r_cur_digit   <= 2'd0;
    end else begin
      r_seg         <= w_seg_d;
      r_dp          <= w_dp_d;
      r_an          <= w_an_d;
      r_frame_start <= w_frame_start_d;
      r_cur_digit   <= r_digit;
    end
  end

  assign wr_ready    = ~r_full;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_frame_start;
  assign cur_digit   = r_cur_digit;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl. It uses a 20-cycle slot and an
// 80-cycle frame. The reference model works from absolute time since reset:
// the slot and position come from the cycle number, and the frames are
// plain variables.

module tb_sevenseg_scan_ctrl;

  localparam int ClkFreq = 80;
  localparam int RefreshHz = 1;
  localparam int Blank = 4;
  localparam int P = 20;
  localparam int Step = 2;
  localparam int Frame = 80;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [19:0] wr_data;
  logic [2:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  logic [1:0]  cur_digit;

  int n_tests = 0;
  int n_fail = 0;

  sevenseg_scan_ctrl #(
    .CLK_FREQ(ClkFreq),
    .REFRESH_HZ(RefreshHz),
    .BLANK_CYCLES(Blank)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .brightness(brightness),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_start(frame_start),
    .cur_digit(cur_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tab[h];
  endfunction

  // Reference model: m_t is the index of the cycle whose state the next
  // edge reflects.
  int          m_t;
  int          m_pos;
  int          m_slot;
  int          m_b;
  bit          m_on;
  logic [4:0]  m_nib;
  logic [19:0] m_active;
  logic [19:0] m_shadow;
  logic        m_full;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fs;
  logic [1:0]  e_cur;
  logic        e_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t      = 0;
      m_b      = 0;
      m_active = 20'd0;
      m_shadow = 20'd0;
      m_full   = 1'b0;
      e_an     = 4'hf;
      e_seg    = 7'h7f;
      e_dp     = 1'b1;
      e_fs     = 1'b0;
      e_cur    = 2'd0;
      e_ready  = 1'b1;
    end else begin
      m_pos  = m_t % P;
      m_slot = (m_t / P) % 4;
      if (m_pos == 0) m_b = int'(brightness);
      m_on   = (m_pos >= Blank) && ((m_pos - Blank) < Step * (m_b + 1));
      m_nib  = m_active[5*m_slot +: 5];
      e_an   = m_on ? ~(4'b0001 << m_slot) : 4'hf;
      e_seg  = m_on ? hex_seg(m_nib[3:0]) : 7'h7f;
      e_dp   = m_on ? ~m_nib[4] : 1'b1;
      e_fs   = (m_t % Frame) == 0;
      e_cur  = 2'(m_slot);
      if (((m_t % Frame) == Frame - 1) && m_full) begin
        m_active = m_shadow;
        m_full   = 1'b0;
      end else if (wr_valid && !m_full) begin
        m_shadow = wr_data;
        m_full   = 1'b1;
      end
      e_ready = !m_full;
      m_t++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    @(negedge clk);
    check("cycle", 32'({an, seg, dp, frame_start, cur_digit, wr_ready}),
          32'({e_an, e_seg, e_dp, e_fs, e_cur, e_ready}));
  endtask

  task automatic run_to(input int target);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (((m_t % Frame) != target) && (k < 2 * Frame));
  endtask

  task automatic write_frame(input logic [19:0] data);
    logic rdy;
    bit   done;
    done     = 1'b0;
    wr_data  = data;
    wr_valid = 1'b1;
    for (int k = 0; k < 3 * Frame && !done; k++) begin
      rdy = wr_ready;
      tick();
      done = rdy;
    end
    wr_valid = 1'b0;
    check("write_accepted", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [19:0] a_frame;
    logic [19:0] b_frame;
    logic [19:0] c_frame;
    logic [19:0] d_frame;
    logic        rdy;
    int          lows [4];

    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 20'd0;
    brightness = 3'd7;

    // Reset state
    repeat (3) tick();
    check("rst_an", 32'(an), 32'hf);
    check("rst_seg", 32'(seg), 32'h7f);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_cur", 32'(cur_digit), 32'd0);

    // Idle display after release, brightness 7
    rst_n = 1'b1;
    repeat (Frame) begin
      tick();
      if (m_t == 1) check("t1_frame_start", 32'(frame_start), 32'd1);
      if (m_t >= 5 && m_t <= 20) begin
        check("t1_an0", 32'(an), 32'b1110);
        check("t1_seg0", 32'(seg), 32'(7'b1000000));
      end
      if (m_t >= 25 && m_t <= 40) check("t1_an1", 32'(an), 32'b1101);
      if (m_t <= 4 || (m_t >= 21 && m_t <= 24)) check("t1_blank", 32'(an), 32'hf);
    end
    tick();
    check("t1_frame_start_next", 32'(frame_start), 32'd1);

    // Frame load: digits 1, 8, F(dp), A
    write_frame({5'h0A, 5'h1F, 5'h08, 5'h01});
    check("t2_ready_low", 32'(wr_ready), 32'd0);
    run_to(50);
    check("t2_old_an2", 32'(an), 32'b1011);
    check("t2_old_seg2", 32'(seg), 32'(7'b1000000));
    check("t2_old_dp2", 32'(dp), 32'd1);
    run_to(10);
    check("t2_new_seg0", 32'(seg), 32'(7'b1111001));
    check("t2_new_dp0", 32'(dp), 32'd1);
    check("t2_ready_high", 32'(wr_ready), 32'd1);
    run_to(30);
    check("t2_new_seg1", 32'(seg), 32'(7'b0000000));
    run_to(50);
    check("t2_new_seg2", 32'(seg), 32'(7'b0001110));
    check("t2_new_dp2", 32'(dp), 32'd0);

    // Brightness: per-digit low time over one full frame
    brightness = 3'd0;
    repeat (Frame) tick();
    lows = '{0, 0, 0, 0};
    repeat (Frame) begin
      tick();
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) lows[i]++;
    end
    for (int i = 0; i < 4; i++) check("t3_b0_width", 32'(lows[i]), 32'd2);
    brightness = 3'd3;
    repeat (Frame) tick();
    lows = '{0, 0, 0, 0};
    repeat (Frame) begin
      tick();
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) lows[i]++;
    end
    for (int i = 0; i < 4; i++) check("t3_b3_width", 32'(lows[i]), 32'd8);
    // Mid-slot change only affects the following slot
    run_to(22);
    brightness = 3'd7;
    lows = '{0, 0, 0, 0};
    repeat (19) begin
      tick();
      if (an[1] == 1'b0) lows[1]++;
    end
    repeat (20) begin
      tick();
      if (an[2] == 1'b0) lows[2]++;
    end
    check("t3_mid_slot_old", 32'(lows[1]), 32'd8);
    check("t3_mid_slot_new", 32'(lows[2]), 32'd16);

    // Back-pressure: B waits until A is swapped in
    run_to(2);
    a_frame = {15'($urandom), 5'h01};
    b_frame = {15'($urandom), 5'h02};
    write_frame(a_frame);
    check("t4_ready_low", 32'(wr_ready), 32'd0);
    write_frame(b_frame);
    check("t4_b_accept_time", 32'(m_t % Frame), 32'd1);
    run_to(10);
    check("t4_a_shown", 32'(seg), 32'(7'b1111001));
    run_to(10);
    check("t4_b_shown", 32'(seg), 32'(7'b0100100));

    // Write accepted on the swap edge itself
    run_to(79);
    c_frame  = {15'($urandom), 5'h07};
    wr_data  = c_frame;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("t5_ready_low", 32'(wr_ready), 32'd0);
    run_to(10);
    check("t5_not_swapped", 32'(seg), 32'(7'b0100100));
    run_to(10);
    check("t5_swapped_later", 32'(seg), 32'(7'b1111000));

    // Randomized writes and brightness changes
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
      if (!wr_valid && $urandom_range(0, 5) == 0) begin
        wr_valid = 1'b1;
        wr_data  = 20'($urandom);
      end
      rdy = wr_ready;
      tick();
      if (wr_valid && rdy) wr_valid = 1'b0;
    end
    wr_valid   = 1'b0;
    brightness = 3'd7;

    // Reset mid-ON of digit 2 with a frame pending
    repeat (2 * Frame) tick();
    run_to(2);
    d_frame = {5'h0A, 5'h1F, 5'h08, 5'h03};
    write_frame(d_frame);
    run_to(50);
    check("t6_pre_an2", 32'(an), 32'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_an", 32'(an), 32'hf);
    check("t6_async_seg", 32'(seg), 32'h7f);
    check("t6_async_dp", 32'(dp), 32'd1);
    check("t6_async_fs", 32'(frame_start), 32'd0);
    check("t6_async_cur", 32'(cur_digit), 32'd0);
    check("t6_async_ready", 32'(wr_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2 * Frame) begin
      tick();
      if ((m_t % Frame) >= 5 && (m_t % Frame) <= 20) begin
        check("t6_an0", 32'(an), 32'b1110);
        check("t6_seg0", 32'(seg), 32'(7'b1000000));
      end
      if ((m_t % Frame) >= 45 && (m_t % Frame) <= 60) begin
        check("t6_an2", 32'(an), 32'b1011);
        check("t6_seg2", 32'(seg), 32'(7'b1000000));
        check("t6_dp2", 32'(dp), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
